tri_check_master: RTL and testbench

Avalon-MM master that drives the triangle-check slave. Accepts side-length triplets on a valid/ready command port, writes them to the slave's A/B/C registers, reads back the result register, and presents the verdict on a valid/ready result port. It sits directly upstream of the slave and turns its register-level protocol into one command → one verdict. Strictly one triplet in flight; no internal queueing beyond one command and one result register.

---
 rtl/tri_check_master_pkg.sv | 20 ++
 rtl/tri_check_master_if.sv | 41 ++++
 rtl/tri_wait_watchdog.sv | 27 ++
 rtl/tri_check_master.sv | 150 +++++++++++++++
 tb/tb_tri_check_master.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_check_master_pkg.sv
// Shared FSM state and register-address definitions for the triangle-check master.
// The optional watchdog is enabled with the TRI_MASTER_TIMEOUT_EN macro.
package tri_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    WR_C,
    RD_RES,
    RD_WAIT,
    OUT
  } state_t;

  localparam logic [1:0] ADDR_A      = 2'd0;
  localparam logic [1:0] ADDR_B      = 2'd1;
  localparam logic [1:0] ADDR_C      = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

endpackage

// File: rtl/tri_check_master_if.sv
// Command, Avalon-MM and verdict signals of the triangle-check master.
// master = the tri_check_master view, slave = the surrounding environment.
interface tri_check_master_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_c;

  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  logic        out_valid;
  logic        out_ready;
  logic        out_result;
  logic        out_timeout;

  modport master (
    input  in_valid, in_a, in_b, in_c,
    output in_ready,
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest,
    output out_valid, out_result, out_timeout,
    input  out_ready
  );

  modport slave (
    output in_valid, in_a, in_b, in_c,
    input  in_ready,
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest,
    input  out_valid, out_result, out_timeout,
    output out_ready
  );

endinterface

// File: rtl/tri_wait_watchdog.sv
// Stall watchdog: counts waitrequest-stalled cycles within one FSM state and
// flags expiry on the stall cycle that makes the count reach TIMEOUT_CYCLES.
module tri_wait_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_stall,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expire = i_stall && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_stall) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tri_check_master.sv
// Avalon-MM master: one command -> write A/B/C, read result, one verdict.
// Define TRI_MASTER_TIMEOUT_EN to add the waitrequest watchdog (out_timeout).
module tri_check_master
  import tri_master_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset,
  tri_check_master_if.master  bus
);

  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t            r_state;
  state_t            w_next_base;
  state_t            w_next;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_c;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_result;
  logic              w_lat_done;
  logic              w_req_phase;
  logic              w_stall;
  logic              w_expire;
  logic              w_unused_rdata;

  assign w_unused_rdata = ^bus.avm_readdata[31:1];
  assign w_lat_done     = (r_lat_cnt == LAT_W'(READ_LATENCY - 1));
  assign w_req_phase    = (r_state == WR_A) || (r_state == WR_B) ||
                          (r_state == WR_C) || (r_state == RD_RES);
  assign w_stall        = w_req_phase && bus.avm_waitrequest;

  always_comb begin
    w_next_base = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)          w_next_base = WR_A;
      WR_A:    if (!bus.avm_waitrequest)  w_next_base = WR_B;
      WR_B:    if (!bus.avm_waitrequest)  w_next_base = WR_C;
      WR_C:    if (!bus.avm_waitrequest)  w_next_base = RD_RES;
      RD_RES:  if (!bus.avm_waitrequest)  w_next_base = RD_WAIT;
      RD_WAIT: if (w_lat_done)            w_next_base = OUT;
      OUT:     if (bus.out_ready)         w_next_base = IDLE;
      default:                            w_next_base = IDLE;
    endcase
  end

  // Watchdog override kept outside the case so the counter clear has no loop through it.
  assign w_next = w_expire ? OUT : w_next_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_lat_cnt <= '0;
      r_result  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.in_valid) begin
        r_a <= bus.in_a;
        r_b <= bus.in_b;
        r_c <= bus.in_c;
      end
      if (r_state == RD_WAIT) begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end else begin
        r_lat_cnt <= '0;
      end
      if (w_expire) begin
        r_result <= 1'b0;
      end else if (r_state == RD_WAIT && w_lat_done) begin
        r_result <= bus.avm_readdata[0];
      end
    end
  end

  always_comb begin
    bus.avm_address   = ADDR_A;
    bus.avm_writedata = '0;
    bus.avm_write     = 1'b0;
    bus.avm_read      = 1'b0;
    case (r_state)
      WR_A: begin
        bus.avm_write     = 1'b1;
        bus.avm_address   = ADDR_A;
        bus.avm_writedata = r_a;
      end
      WR_B: begin
        bus.avm_write     = 1'b1;
        bus.avm_address   = ADDR_B;
        bus.avm_writedata = r_b;
      end
      WR_C: begin
        bus.avm_write     = 1'b1;
        bus.avm_address   = ADDR_C;
        bus.avm_writedata = r_c;
      end
      RD_RES: begin
        bus.avm_read      = 1'b1;
        bus.avm_address   = ADDR_RESULT;
      end
      default: ;
    endcase
  end

  assign bus.in_ready   = (r_state == IDLE) && !reset;
  assign bus.out_valid  = (r_state == OUT);
  assign bus.out_result = r_result;

`ifdef TRI_MASTER_TIMEOUT_EN
  logic r_timeout;
  logic w_wd_clear;

  assign w_wd_clear = (w_next_base != r_state) || w_expire;

  tri_wait_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_wd_clear),
    .i_stall  (w_stall),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (w_expire) begin
      r_timeout <= 1'b1;
    end else if (r_state == RD_WAIT && w_lat_done) begin
      r_timeout <= 1'b0;
    end
  end

  assign bus.out_timeout = r_timeout;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  logic w_unused_stall;

  assign w_unused_stall  = w_stall;
  assign w_expire        = 1'b0;
  assign bus.out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tri_check_master.sv
// Scoreboard bench for tri_check_master with an Avalon slave model and a
// triangle reference model; the stuck-read case runs with TRI_MASTER_TIMEOUT_EN.
module tb_tri_check_master;
  import tri_master_pkg::*;

  localparam int unsigned L = 1;
`ifdef TRI_MASTER_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  tri_check_master_if bus ();

  tri_check_master #(
    .READ_LATENCY   (L),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic res; logic to; } verdict_t;
  typedef struct { logic [1:0] addr; logic [31:0] data; } wr_t;

  verdict_t exp_q[$];
  wr_t      wr_q[$];
  int hs_cyc = 0, last_in_hs = 0, last_out_hs = 0, txn_stalls = 0;

  function automatic logic tri_ok(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    longint unsigned x, y, z;
    x = a; y = b; z = c;
    return (x + y > z) && (x + z > y) && (y + z > x);
  endfunction

  // Avalon slave model: register file, result register, fixed read latency.
  int stall_mode = 0;   // 0 none, 1 random, 2 hold WR_B, 3 stuck read
  int stall_left = 0;
  int s_run = 0;
  int rd_cnt = 0;
  logic rd_bit = 1'b0;
  logic rd_now;
  logic s_wr;
  logic [31:0] rnd;
  logic [31:0] sreg [3];
  logic p_hold = 1'b0;
  logic [1:0]  p_addr;
  logic [31:0] p_data;
  logic p_rd, p_we;

  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    forever begin
      @(negedge clk);
      case (stall_mode)
        1: s_wr = (s_run < 3) && ($urandom_range(3) == 0);
        2: begin
          s_wr = 1'b0;
          if (bus.avm_write && bus.avm_address == ADDR_B && stall_left > 0) begin
            s_wr = 1'b1;
            stall_left--;
          end
        end
        3: s_wr = bus.avm_read;
        default: s_wr = 1'b0;
      endcase
      s_run = s_wr ? s_run + 1 : 0;
      bus.avm_waitrequest = s_wr;
      rd_now = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        rd_now = (rd_cnt == 0);
      end
      rnd = $urandom();
      bus.avm_readdata = {rnd[31:1], rd_now ? rd_bit : ~rd_bit};
      #1;
      if (reset) begin
        rd_cnt = 0;
        p_hold = 1'b0;
      end else begin
        chk("rw_exclusive", bus.avm_read & bus.avm_write, 0);
        if (p_hold && !bus.out_valid)
          chk("avm_hold", {bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write},
              {p_addr, p_data, p_rd, p_we});
        if ((bus.avm_read || bus.avm_write) && s_wr) txn_stalls++;
        p_hold = (bus.avm_read || bus.avm_write) && s_wr;
        p_addr = bus.avm_address;
        p_data = bus.avm_writedata;
        p_rd   = bus.avm_read;
        p_we   = bus.avm_write;
        if (bus.avm_write && !s_wr) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            chk("wr_addr", bus.avm_address, wr_q[0].addr);
            chk("wr_data", bus.avm_writedata, wr_q[0].data);
            void'(wr_q.pop_front());
          end
          if (bus.avm_address != ADDR_RESULT) sreg[bus.avm_address] = bus.avm_writedata;
        end
        if (bus.avm_read && !s_wr) begin
          chk("rd_addr", bus.avm_address, ADDR_RESULT);
          rd_bit = tri_ok(sreg[0], sreg[1], sreg[2]);
          rd_cnt = L;
        end
      end
    end
  end

  // Verdict monitor and out_ready driver.
  int   or_hold = 0;
  logic or_rand = 1'b0;
  logic m_hold = 1'b0;
  logic m_res, m_to;
  int   exp_lat;

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (or_hold > 0 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        or_hold--;
      end else if (or_rand) begin
        bus.out_ready = 1'($urandom_range(1));
      end else begin
        bus.out_ready = 1'b1;
      end
      #2;
      if (reset) begin
        chk("in_ready_in_reset", bus.in_ready, 0);
        m_hold = 1'b0;
      end else begin
        chk("in_ready", bus.in_ready, (exp_q.size() == 0) || (hs_cyc == cyc));
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_verdict", 1, 0);
          end else begin
            if (!m_hold) begin
              exp_lat = exp_q[0].to ? 4 + txn_stalls : 5 + int'(L) + txn_stalls;
              chk("verdict_latency", cyc - hs_cyc, exp_lat);
            end else begin
              chk("out_hold", {bus.out_result, bus.out_timeout}, {m_res, m_to});
            end
            if (bus.out_ready) begin
              chk("out_result", bus.out_result, exp_q[0].res);
              chk("out_timeout", bus.out_timeout, exp_q[0].to);
              void'(exp_q.pop_front());
              last_out_hs = cyc;
            end
          end
        end
        m_hold = bus.out_valid && !bus.out_ready;
        m_res  = bus.out_result;
        m_to   = bus.out_timeout;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic exp_to);
    int n;
    verdict_t v;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_c = c;
    #1;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("cmd_accept_timeout", 0, 1);
    end else begin
      v.res = exp_to ? 1'b0 : tri_ok(a, b, c);
      v.to  = exp_to;
      exp_q.push_back(v);
      wr_q.push_back('{ADDR_A, a});
      wr_q.push_back('{ADDR_B, b});
      wr_q.push_back('{ADDR_C, c});
      txn_stalls = 0;
      hs_cyc     = cyc;
      last_in_hs = cyc;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a = $urandom(); bus.in_b = $urandom(); bus.in_c = $urandom();
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_side();
    if ($urandom_range(3) == 3) return $urandom();
    return 32'($urandom_range(20));
  endfunction

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_avm", {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata}, 0);
    chk("rst_out", {bus.out_valid, bus.out_result, bus.out_timeout}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    send(3, 4, 5, 1'b0);   wait_idle(50);
    send(1, 2, 3, 1'b0);   wait_idle(50);
    send(7, 7, 7, 1'b0);   wait_idle(50);

    stall_mode = 2; stall_left = 5;
    send(10, 20, 25, 1'b0); wait_idle(50);
    stall_mode = 0;

    or_hold = 10;
    send(2, 3, 4, 1'b0);
    send(6, 8, 10, 1'b0);
    chk("accept_after_out_hs", last_in_hs, last_out_hs + 1);
    wait_idle(50);

    send(8, 9, 10, 1'b0);
    n = 0;
    while (!(bus.avm_write && bus.avm_address == ADDR_C) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wr_c", bus.avm_write && bus.avm_address == ADDR_C, 1);
    reset = 1'b1;
    exp_q.delete();
    wr_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_avm", {bus.avm_write, bus.avm_read, bus.out_valid}, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    send(5, 5, 9, 1'b0);   wait_idle(50);

    or_rand = 1'b1; stall_mode = 1;
    for (int i = 0; i < 40; i++) send(rand_side(), rand_side(), rand_side(), 1'b0);
    wait_idle(500);
    or_rand = 1'b0; stall_mode = 0;

`ifdef TRI_MASTER_TIMEOUT_EN
    stall_mode = 3;
    send(3, 4, 5, 1'b1);
    wait_idle(100);
    wr_q.delete();
    stall_mode = 0;
    send(3, 4, 5, 1'b0);   wait_idle(50);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within 50000 cycles");
    $fatal(1, "timeout");
  end

endmodule
